// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the receive FIFO and its consumer.
// slave is the FIFO side, master is the receiver/consumer side.
`timescale 1ns/1ps
interface uart_rx_fifo_if #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 16
);
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic [BUS_WIDTH-1:0] in_data;
  logic                 in_valid;
  logic [BUS_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_WIDTH-1:0] count;
  logic                 full;
  logic                 overflow;
  logic                 ovf_clr;
  logic                 timeout;

  modport slave (
    input  in_data, in_valid, out_ready, ovf_clr,
    output out_data, out_valid, count, full, overflow, timeout
  );

  modport master (
    output in_data, in_valid, out_ready, ovf_clr,
    input  out_data, out_valid, count, full, overflow, timeout
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind a UART receiver: strobe-in, valid/ready out,
// occupancy, sticky overflow and idle-line timeout.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int BUS_WIDTH      = 8,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 17360
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [TMO_WIDTH-1:0] TMO_MAX  = TMO_WIDTH'(TIMEOUT_CYCLES);

  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] count_q;
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic                 overflow_q;

  logic empty;
  logic full;
  logic rd;
  logic wr;
  logic drop;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // byte when the consumer is draining; only a write with no read is dropped.
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign rd    = !empty && bus.out_ready;
  assign wr    = bus.in_valid && (!full || rd);
  assign drop  = bus.in_valid && full && !rd;

  // Storage write; reset-cycle strobes are ignored.
  // NOTE: the array has no reset -- pointers and count define which entries are
  // live, so clearing the data would only add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (rst && wr) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointers and occupancy count; pointers wrap naturally at DEPTH.
  // NOTE: every register here uses <= so all blocks see the pre-edge values of
  // wr/rd/count_q regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (rd) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({wr, rd})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow: a drop wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  // Idle-line counter: restarts on every accepted byte or while empty,
  // otherwise counts up and parks at TIMEOUT_CYCLES. Reads do not restart it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (wr || empty) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
    end
  end

  assign bus.out_data  = empty ? '0 : mem[rd_ptr];
  assign bus.out_valid = !empty;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.overflow  = overflow_q;
  assign bus.timeout   = (tmo_cnt == TMO_MAX) && !empty;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It accepts each completed byte as a one-cycle strobe, stores it in a power-of-two FIFO, and presents bytes to the consumer over a valid/ready handshake. It also reports occupancy, a sticky overflow flag, and an idle-line timeout that tells software to drain a partially filled buffer.

## Interface
Parameters:
- BUS_WIDTH, 8, byte width; must equal the receiver data width.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 17360, idle clocks before timeout. The default is 4 character times: 434 clk/bit × 10 bits × 4, at 115200 baud with a 50 MHz clock.
- Derived: PTR_WIDTH = $clog2(DEPTH); CNT_WIDTH = PTR_WIDTH+1; TMO_WIDTH = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- in_data  in  BUS_WIDTH  received byte from the UART receiver.
- in_valid  in  1  one-cycle strobe; in_data is valid this cycle.
- out_data  out  BUS_WIDTH  head-of-FIFO byte; 0 when empty.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head byte when out_valid && out_ready.
- count  out  CNT_WIDTH  entries stored, 0..DEPTH.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; set when a byte is dropped.
- ovf_clr  in  1  clears overflow.
- timeout  out  1  FIFO non-empty and line idle for TIMEOUT_CYCLES.

## Operation
- Storage: DEPTH×BUS_WIDTH array. Write pointer and read pointer are PTR_WIDTH bits each, with natural wrap DEPTH-1 → 0. The count register is kept separately, CNT_WIDTH bits. The memory array is not reset.
- Write accept: wr = in_valid && (!full || rd). A byte that arrives while full with no read in the same cycle is dropped: memory, pointers and count are unchanged and overflow is set.
- Read: rd = out_valid && out_ready. The read pointer advances and the head entry is released.
- Count: +1 on wr only, −1 on rd only, unchanged on both or neither.
- Simultaneous read and write when full: both happen, count stays DEPTH, and overflow is not set.
- Simultaneous read and write when count == 1: the written byte becomes the head next cycle and out_valid stays 1.
- Output data: out_data = mem[rd_ptr] when count != 0, otherwise 0.
- Overflow flag:
  - A set event (drop) has priority over ovf_clr in the same cycle.
  - Otherwise ovf_clr=1 clears the flag.
- Timeout counter (tmo_cnt):
  - Cleared on any accepted write, and whenever count == 0.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - timeout = (tmo_cnt == TIMEOUT_CYCLES) && (count != 0).
  - timeout therefore stays high until the next write or until the FIFO drains empty; reads alone do not clear it.
- Reset (rst=0 at a clock edge): pointers, count, tmo_cnt, overflow and timeout all go to 0. Any stored bytes are discarded. An in_valid in the reset cycle is ignored. Reset applied mid-stream has the same effect.

## Timing
- Reset values: out_valid=0, out_data=0, count=0, full=0, overflow=0, timeout=0.
- Write-to-output latency is 1 cycle. A strobe at edge N into an empty FIFO gives out_valid=1 with out_data equal to that byte after edge N.
- out_valid, full and count are registered (or decoded from registered count) and are stable for the whole cycle. out_ready may be combinational from the consumer.
- Read-to-next-head latency is 1 cycle. The next byte appears on out_data in the cycle after the accepting edge.
- Throughput is one write and one read per cycle.
- overflow rises the cycle after the dropping edge. timeout rises on the edge where tmo_cnt reaches TIMEOUT_CYCLES.
- in_valid is assumed to be a one-cycle pulse. A pulse held for k cycles is treated as k bytes.

## Test plan
- Reset then single byte: rst=0 for 2 cycles, then in_data=0xA5 strobe with out_ready=0.
  - Required: out_valid=1, out_data=0xA5, count=1 one cycle later.
  - Then out_ready=1 for 1 cycle: out_valid=0, out_data=0x00, count=0.
- Fill and overflow: with out_ready=0, write 0x00..0x10 (17 bytes, DEPTH=16).
  - Required: full=1 after 16 writes, count=16, overflow=1 after the 17th.
  - Draining yields 0x00..0x0F in order, and 0x10 is never seen.
  - ovf_clr=1 then gives overflow=0.
- Full with simultaneous read and write: FIFO full, in_valid=1 with 0x55 and out_ready=1 in the same cycle.
  - Required: count stays 16, overflow stays 0, and 0x55 is the last byte drained.
- Pointer wrap-around: stream 40 bytes (0x30..0x57) with out_ready toggling 1/0 every cycle.
  - Required: output order is exact, with no loss or duplication, and count never exceeds 16.
- Timeout (TIMEOUT_CYCLES=20 in the bench): write 3 bytes, then idle.
  - Required: timeout=1 exactly 20 cycles after the last write. One read leaves timeout=1. A new write drops it to 0.
  - Draining to empty also drops it to 0.
- Reset mid-operation: 5 bytes stored and overflow=1, then rst=0 for one edge with in_valid=1.
  - Required: count=0, out_valid=0, overflow=0, timeout=0. The strobed byte does not appear.
